// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the three writeback sources and the register-file write port.
// Handshake: a source transfers when reqN_valid && reqN_ready in the same cycle; it holds
// valid/rdc/data stable until then, and ready is a same-cycle function of the inputs.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              flush;
   logic              req0_valid, req1_valid, req2_valid;
   logic [ADDR_W-1:0] req0_rdc, req1_rdc, req2_rdc;
   logic [DATA_W-1:0] req0_data, req1_data, req2_data;
   logic              req0_ready, req1_ready, req2_ready;
   logic              regfile_ena;
   logic              regfile_write;
   logic [ADDR_W-1:0] rdc;
   logic [DATA_W-1:0] rd;
   logic [1:0]        grant_id;

   modport master (
      output flush,
      output req0_valid, req1_valid, req2_valid,
      output req0_rdc, req1_rdc, req2_rdc,
      output req0_data, req1_data, req2_data,
      input  req0_ready, req1_ready, req2_ready,
      input  regfile_ena, regfile_write, rdc, rd, grant_id
   );

   modport slave (
      input  flush,
      input  req0_valid, req1_valid, req2_valid,
      input  req0_rdc, req1_rdc, req2_rdc,
      input  req0_data, req1_data, req2_data,
      output req0_ready, req1_ready, req2_ready,
      output regfile_ena, regfile_write, rdc, rd, grant_id
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Three-source writeback arbiter driving a registered register-file write port.
// Optional per-source stall counters are built when WB_ARB_PERF_EN is defined.
module rf_wb_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int PRIO_MODE = 0,
   parameter int CNT_W     = 16
) (
   input  logic               rf_wb_arbiter_clk,
   input  logic               rf_wb_arbiter_rst_n,
   rf_wb_arbiter_if.slave     bus,
   output logic [1:0]         rr_ptr_dbg
`ifdef WB_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt0,
   output logic [CNT_W-1:0]   stall_cnt1,
   output logic [CNT_W-1:0]   stall_cnt2
`endif
);

   logic [2:0]        valid;
   logic [2:0]        ready;
   logic              grant_vld;
   logic [1:0]        grant_idx;
   logic [1:0]        cand;
   logic [ADDR_W-1:0] sel_rdc;
   logic [DATA_W-1:0] sel_data;

   logic              regfile_ena_q, regfile_ena_d;
   logic              regfile_write_q, regfile_write_d;
   logic [ADDR_W-1:0] rdc_q, rdc_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [1:0]        grant_id_q, grant_id_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;

   assign valid = {bus.req2_valid, bus.req1_valid, bus.req0_valid};

   // Fixed priority is round-robin with the search always starting at source 0.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      cand      = (PRIO_MODE != 0) ? 2'd0 : rr_ptr_q;
      for (int i = 0; i < 3; i++) begin
         if (!grant_vld && !bus.flush && valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      end
      ready = grant_vld ? (3'b001 << grant_idx) : 3'b000;
   end

   always_comb begin
      sel_rdc  = bus.req0_rdc;
      sel_data = bus.req0_data;
      case (grant_idx)
         2'd1: begin
            sel_rdc  = bus.req1_rdc;
            sel_data = bus.req1_data;
         end
         2'd2: begin
            sel_rdc  = bus.req2_rdc;
            sel_data = bus.req2_data;
         end
         default: ;
      endcase
   end

   // A grant to r0 still consumes the request and advances the pointer, but never writes.
   always_comb begin
      regfile_ena_d   = 1'b1;
      regfile_write_d = grant_vld && (sel_rdc != '0);
      rdc_d           = grant_vld ? sel_rdc : rdc_q;
      rd_d            = grant_vld ? sel_data : rd_q;
      grant_id_d      = grant_vld ? grant_idx : 2'd3;
      rr_ptr_d        = rr_ptr_q;
      if (bus.flush) begin
         rr_ptr_d = 2'd0;
      end else if (grant_vld && (PRIO_MODE == 0)) begin
         rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
   end

   always_ff @(posedge rf_wb_arbiter_clk or negedge rf_wb_arbiter_rst_n) begin
      if (!rf_wb_arbiter_rst_n) begin
         regfile_ena_q   <= 1'b0;
         regfile_write_q <= 1'b0;
         rdc_q           <= '0;
         rd_q            <= '0;
         grant_id_q      <= 2'd3;
         rr_ptr_q        <= 2'd0;
      end else begin
         regfile_ena_q   <= regfile_ena_d;
         regfile_write_q <= regfile_write_d;
         rdc_q           <= rdc_d;
         rd_q            <= rd_d;
         grant_id_q      <= grant_id_d;
         rr_ptr_q        <= rr_ptr_d;
      end
   end

   assign bus.req0_ready    = ready[0];
   assign bus.req1_ready    = ready[1];
   assign bus.req2_ready    = ready[2];
   assign bus.regfile_ena   = regfile_ena_q;
   assign bus.regfile_write = regfile_write_q;
   assign bus.rdc           = rdc_q;
   assign bus.rd            = rd_q;
   assign bus.grant_id      = grant_id_q;
   assign rr_ptr_dbg        = rr_ptr_q;

`ifdef WB_ARB_PERF_EN
   logic [CNT_W-1:0] stall_q [3];
   logic [CNT_W-1:0] stall_d [3];

   // Flush cycles count as stalls; counters saturate rather than wrap.
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         stall_d[n] = stall_q[n];
         if (valid[n] && !ready[n] && (stall_q[n] != '1)) begin
            stall_d[n] = stall_q[n] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge rf_wb_arbiter_clk or negedge rf_wb_arbiter_rst_n) begin
      if (!rf_wb_arbiter_rst_n) begin
         for (int n = 0; n < 3; n++) stall_q[n] <= '0;
      end else begin
         for (int n = 0; n < 3; n++) stall_q[n] <= stall_d[n];
      end
   end

   assign stall_cnt0 = stall_q[0];
   assign stall_cnt1 = stall_q[1];
   assign stall_cnt2 = stall_q[2];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: round-robin instance driven from a vector table,
// plus fixed-priority, reset and flush/stall-counter sequences.
module tb_rf_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;

   logic clk;
   logic rst_n;
   logic [1:0] ptr_rr, ptr_fp;
   int checks;
   int errors;

`ifdef WB_ARB_PERF_EN
   logic [CW-1:0] rr_s0, rr_s1, rr_s2, fp_s0, fp_s1, fp_s2;
`endif

   rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rr ();
   rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fp ();

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0), .CNT_W(CW)) dut_rr (
      .rf_wb_arbiter_clk   (clk),
      .rf_wb_arbiter_rst_n (rst_n),
      .bus                 (bus_rr.slave),
      .rr_ptr_dbg          (ptr_rr)
`ifdef WB_ARB_PERF_EN
      ,
      .stall_cnt0          (rr_s0),
      .stall_cnt1          (rr_s1),
      .stall_cnt2          (rr_s2)
`endif
   );

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1), .CNT_W(CW)) dut_fp (
      .rf_wb_arbiter_clk   (clk),
      .rf_wb_arbiter_rst_n (rst_n),
      .bus                 (bus_fp.slave),
      .rr_ptr_dbg          (ptr_fp)
`ifdef WB_ARB_PERF_EN
      ,
      .stall_cnt0          (fp_s0),
      .stall_cnt1          (fp_s1),
      .stall_cnt2          (fp_s2)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic          flush;
      logic [2:0]    v;
      logic [AW-1:0] rdc0, rdc1, rdc2;
      logic [DW-1:0] d0, d1, d2;
      logic [2:0]    e_rdy;
      logic          e_wr;
      logic [AW-1:0] e_rdc;
      logic [DW-1:0] e_rd;
      logic [1:0]    e_gid;
      logic [1:0]    e_ptr;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic f, input logic [2:0] v,
                               input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                               input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                               input logic [AW-1:0] r2, input logic [DW-1:0] d2,
                               input logic [2:0] e_rdy, input logic e_wr,
                               input logic [AW-1:0] e_rdc, input logic [DW-1:0] e_rd,
                               input logic [1:0] e_gid, input logic [1:0] e_ptr);
      vec_t t;
      t.flush = f;  t.v = v;
      t.rdc0 = r0;  t.d0 = d0;  t.rdc1 = r1;  t.d1 = d1;  t.rdc2 = r2;  t.d2 = d2;
      t.e_rdy = e_rdy;  t.e_wr = e_wr;  t.e_rdc = e_rdc;  t.e_rd = e_rd;
      t.e_gid = e_gid;  t.e_ptr = e_ptr;
      return t;
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive_rr(input vec_t t);
      bus_rr.flush      = t.flush;
      bus_rr.req0_valid = t.v[0];  bus_rr.req0_rdc = t.rdc0;  bus_rr.req0_data = t.d0;
      bus_rr.req1_valid = t.v[1];  bus_rr.req1_rdc = t.rdc1;  bus_rr.req1_data = t.d1;
      bus_rr.req2_valid = t.v[2];  bus_rr.req2_rdc = t.rdc2;  bus_rr.req2_data = t.d2;
   endtask

   task automatic drive_fp(input logic [2:0] v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input logic [AW-1:0] r2);
      bus_fp.flush      = 1'b0;
      bus_fp.req0_valid = v[0];  bus_fp.req0_rdc = r0;  bus_fp.req0_data = 32'h11;
      bus_fp.req1_valid = v[1];  bus_fp.req1_rdc = r1;  bus_fp.req1_data = 32'h22;
      bus_fp.req2_valid = v[2];  bus_fp.req2_rdc = r2;  bus_fp.req2_data = 32'h33;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] rdy_rr();
      return {bus_rr.req2_ready, bus_rr.req1_ready, bus_rr.req0_ready};
   endfunction

   function automatic logic [2:0] rdy_fp();
      return {bus_fp.req2_ready, bus_fp.req1_ready, bus_fp.req0_ready};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive_rr(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive_fp(3'b000, 0, 0, 0);

      tbl[0]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b001, 1, 1, 32'hA0, 0, 1);
      tbl[1]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b010, 1, 2, 32'hA1, 1, 2);
      tbl[2]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b100, 1, 3, 32'hA2, 2, 0);
      tbl[3]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b001, 1, 1, 32'hA0, 0, 1);
      tbl[4]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b010, 1, 2, 32'hA1, 1, 2);
      tbl[5]  = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b100, 1, 3, 32'hA2, 2, 0);
      tbl[6]  = mk(0, 3'b000, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b000, 0, 3, 32'hA2, 3, 0);
      tbl[7]  = mk(0, 3'b010, 1, 32'hA0, 0, 32'hDEADBEEF, 3, 32'hA2, 3'b010, 0, 0, 32'hDEADBEEF, 1, 2);
      tbl[8]  = mk(1, 3'b100, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b000, 0, 0, 32'hDEADBEEF, 3, 0);
      tbl[9]  = mk(0, 3'b011, 5, 32'h1, 5, 32'h2, 3, 32'hA2, 3'b001, 1, 5, 32'h1, 0, 1);
      tbl[10] = mk(0, 3'b010, 5, 32'h1, 5, 32'h2, 3, 32'hA2, 3'b010, 1, 5, 32'h2, 1, 2);
      tbl[11] = mk(0, 3'b111, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b100, 1, 3, 32'hA2, 2, 0);
      tbl[12] = mk(0, 3'b110, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b010, 1, 2, 32'hA1, 1, 2);
      tbl[13] = mk(0, 3'b011, 1, 32'hA0, 2, 32'hA1, 3, 32'hA2, 3'b001, 1, 1, 32'hA0, 0, 1);
      tbl[14] = mk(0, 3'b101, 1, 32'hA0, 2, 32'hA1, 31, 32'hFFFFFFFF, 3'b100, 1, 31, 32'hFFFFFFFF, 2, 0);

      // reset state
      #12;
      chk("rst_ena",   bus_rr.regfile_ena, 0);
      chk("rst_write", bus_rr.regfile_write, 0);
      chk("rst_rdc",   bus_rr.rdc, 0);
      chk("rst_rd",    bus_rr.rd, 0);
      chk("rst_gid",   bus_rr.grant_id, 3);
      chk("rst_ptr",   ptr_rr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ena_after_rst", bus_rr.regfile_ena, 1);

      // round-robin vector table
      for (int i = 0; i < 15; i++) begin
         drive_rr(tbl[i]);
         #1;
         chk($sformatf("v%0d_ready", i), rdy_rr(), tbl[i].e_rdy);
         tick();
         chk($sformatf("v%0d_write", i), bus_rr.regfile_write, tbl[i].e_wr);
         chk($sformatf("v%0d_rdc", i),   bus_rr.rdc, tbl[i].e_rdc);
         chk($sformatf("v%0d_rd", i),    bus_rr.rd, tbl[i].e_rd);
         chk($sformatf("v%0d_gid", i),   bus_rr.grant_id, tbl[i].e_gid);
         chk($sformatf("v%0d_ptr", i),   ptr_rr, tbl[i].e_ptr);
      end

      // fixed priority: req0 beats req2 three times, then lower sources get through
      for (int k = 0; k < 3; k++) begin
         drive_fp(3'b101, 7, 0, 9);
         #1;
         chk($sformatf("fp%0d_ready", k), rdy_fp(), 3'b001);
         tick();
         chk($sformatf("fp%0d_gid", k), bus_fp.grant_id, 0);
         chk($sformatf("fp%0d_rdc", k), bus_fp.rdc, 7);
      end
      drive_fp(3'b110, 0, 12, 9);
      #1;
      chk("fp_r1_ready", rdy_fp(), 3'b010);
      tick();
      chk("fp_r1_gid", bus_fp.grant_id, 1);
      chk("fp_r1_rd", bus_fp.rd, 32'h22);
      drive_fp(3'b100, 0, 0, 9);
      #1;
      chk("fp_r2_ready", rdy_fp(), 3'b100);
      tick();
      chk("fp_r2_gid", bus_fp.grant_id, 2);
      chk("fp_r2_write", bus_fp.regfile_write, 1);

      // reset mid-cycle drops the registered write immediately (tbl[14] left a write up)
      drive_rr(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive_fp(3'b000, 0, 0, 0);
      chk("pre_rst_write", bus_rr.regfile_write, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_write", bus_rr.regfile_write, 0);
      chk("mid_rst_gid",   bus_rr.grant_id, 3);
      chk("mid_rst_ena",   bus_rr.regfile_ena, 0);
      chk("mid_rst_rdc",   bus_rr.rdc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rerst_ena", bus_rr.regfile_ena, 1);

      // two-cycle flush with req2 pending, then a loss to req0, then req2 wins
      for (int k = 0; k < 2; k++) begin
         drive_rr(mk(1, 3'b100, 0, 0, 0, 0, 4, 32'h44, 0, 0, 0, 0, 0, 0));
         #1;
         chk($sformatf("fl%0d_ready", k), rdy_rr(), 3'b000);
         tick();
         chk($sformatf("fl%0d_gid", k),   bus_rr.grant_id, 3);
         chk($sformatf("fl%0d_write", k), bus_rr.regfile_write, 0);
         chk($sformatf("fl%0d_ptr", k),   ptr_rr, 0);
      end
      drive_rr(mk(0, 3'b101, 6, 32'h66, 0, 0, 4, 32'h44, 0, 0, 0, 0, 0, 0));
      #1;
      chk("loss_ready", rdy_rr(), 3'b001);
      tick();
      chk("loss_gid", bus_rr.grant_id, 0);
      drive_rr(mk(0, 3'b100, 0, 0, 0, 0, 4, 32'h44, 0, 0, 0, 0, 0, 0));
      #1;
      chk("win_ready", rdy_rr(), 3'b100);
      tick();
      chk("win_gid", bus_rr.grant_id, 2);
      chk("win_rdc", bus_rr.rdc, 4);
      chk("win_rd",  bus_rr.rd, 32'h44);
`ifdef WB_ARB_PERF_EN
      chk("stall_cnt2", rr_s2, 3);
      chk("stall_cnt1", rr_s1, 0);
      chk("stall_cnt0", rr_s0, 0);
`endif
      drive_rr(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      chk("idle_gid", bus_rr.grant_id, 3);
      chk("idle_rdc_hold", bus_rr.rdc, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
